datamemory_dma: RTL

//  Bus-master engine that drives the datamemory port (address/WR_RD/dataIn, reads dataOut).

---
 rtl/datamemory_dma.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/datamemory_dma.sv
// -----------------------------------------------------------------------------
// datamemory_dma
//
// Bus-master engine for the datamemory port. It performs two kinds of block
// operation of LEN words:
//   COPY (mode=0): read src+i, then write dst+i, strictly ascending.
//   FILL (mode=1): write dst+i with a pattern. The pattern starts at fill_value
//                  and grows by fill_step per word (step 0 gives a constant fill).
// The engine owns the datamemory port while busy. When idle it parks with
// WR_RD=1, so it never writes.
//
// Ports
//   clk, rst_n   rising-edge clock, synchronous active-low reset
//   start        one-cycle command strobe, honoured only in IDLE
//   mode         0 = COPY, 1 = FILL (latched with start)
//   src_addr     COPY source base address (latched with start)
//   dst_addr     destination base address (latched with start)
//   len          word count 0..2^ADDR_WIDTH (latched with start)
//   fill_value   FILL first word; fill_step: FILL per-word increment
//   busy         high from the first issue cycle through the last write cycle
//   done         one-cycle completion pulse (never raised by an aborted command)
//   words_done   words written by the current or last command
//   address      datamemory address
//   WR_RD        datamemory direction (1 = read, 0 = write)
//   dataIn       datamemory write data
//   dataOut      datamemory read data, valid one cycle after a read address
//
// All outputs are registered. Each output's next value is derived from the
// next state, so the pins line up with the state that is currently active.
// -----------------------------------------------------------------------------
module datamemory_dma #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [DATA_WIDTH-1:0] fill_value,
  input  logic [DATA_WIDTH-1:0] fill_step,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_done,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  WR_RD,
  output logic [DATA_WIDTH-1:0] dataIn,
  input  logic [DATA_WIDTH-1:0] dataOut
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Control state.
  state_t                state_q,      state_d;
  logic                  busy_q,       busy_d;
  logic                  done_q,       done_d;
  logic                  wr_rd_q,      wr_rd_d;
  logic [ADDR_WIDTH:0]   words_done_q, words_done_d;
  logic [ADDR_WIDTH:0]   len_q,        len_d;
  logic                  mode_q,       mode_d;

  // Datapath state.
  logic [ADDR_WIDTH-1:0] address_q,    address_d;
  logic [DATA_WIDTH-1:0] data_in_q,    data_in_d;
  logic [ADDR_WIDTH-1:0] src_ptr_q,    src_ptr_d;
  logic [ADDR_WIDTH-1:0] dst_ptr_q,    dst_ptr_d;
  logic [DATA_WIDTH-1:0] pat_q,        pat_d;
  logic [DATA_WIDTH-1:0] step_q,       step_d;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    words_done_d = words_done_q;
    len_d        = len_q;
    mode_d       = mode_q;
    address_d    = address_q;
    data_in_d    = data_in_q;
    src_ptr_d    = src_ptr_q;
    dst_ptr_d    = dst_ptr_q;
    pat_d        = pat_q;
    step_d       = step_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d       = mode;
          len_d        = len;
          src_ptr_d    = src_addr;
          dst_ptr_d    = dst_addr;
          pat_d        = fill_value;
          step_d       = fill_step;
          words_done_d = '0;
          if (len == '0) begin
            // An empty command completes without touching memory.
            state_d = DONE;
          end else if (mode) begin
            state_d   = WR;
            address_d = dst_addr;
            data_in_d = fill_value;
          end else begin
            state_d   = RD;
            address_d = src_addr;
          end
        end
      end

      RD: begin
        // The read address is presented this cycle. The memory returns the
        // word during CAP. The address holds so the read stays stable.
        state_d = CAP;
      end

      CAP: begin
        // data_in_q doubles as the copy buffer. Capturing dataOut here puts
        // the word directly on dataIn for the following WR cycle.
        state_d   = WR;
        data_in_d = dataOut;
        address_d = dst_ptr_q;
      end

      WR: begin
        words_done_d = words_done_q + COUNT_ONE;
        dst_ptr_d    = dst_ptr_q + ADDR_ONE;
        if (mode_q) begin
          pat_d = pat_q + step_q;
        end else begin
          src_ptr_d = src_ptr_q + ADDR_ONE;
        end
        if (words_done_d == len_q) begin
          state_d = DONE;
        end else if (mode_q) begin
          state_d   = WR;
          address_d = dst_ptr_d;
          data_in_d = pat_d;
        end else begin
          state_d   = RD;
          address_d = src_ptr_d;
        end
      end

      DONE: begin
        // start is ignored here; the engine always passes through IDLE.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d == RD) || (state_d == CAP) || (state_d == WR);
    done_d  = (state_d == DONE);
    wr_rd_d = (state_d != WR);
  end

  // Reset covers the control state and the port-facing address and data
  // registers. Command operand registers are always reloaded by start, so
  // they are left out of the reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_rd_q      <= 1'b1;
      words_done_q <= '0;
      address_q    <= '0;
      data_in_q    <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wr_rd_q      <= wr_rd_d;
      words_done_q <= words_done_d;
      address_q    <= address_d;
      data_in_q    <= data_in_d;
      len_q        <= len_d;
      mode_q       <= mode_d;
      src_ptr_q    <= src_ptr_d;
      dst_ptr_q    <= dst_ptr_d;
      pat_q        <= pat_d;
      step_q       <= step_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign words_done = words_done_q;
  assign address    = address_q;
  assign WR_RD      = wr_rd_q;
  assign dataIn     = data_in_q;

endmodule
